// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter. A client keeps the UART for a whole
// message (req held); an optional watchdog revokes the grant from a stalled owner.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter logic [19:0] TIMEOUT_CYC = 20'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   grant,
    input  logic [N_REQ-1:0]   cli_tx_en,
    input  logic [8*N_REQ-1:0] cli_tx_data,
    output logic [N_REQ-1:0]   cli_tx_busy,
    input  logic               uart_tx_busy,
    output logic               uart_tx_en,
    output logic [7:0]         uart_tx_data,
    output logic               timeout_err,
    output logic [1:0]         timeout_id
);
    localparam logic [2:0] NReq = 3'(N_REQ);

    typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] lockout_q, lockout_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       timeout_id_q, timeout_id_d;
    logic [19:0]      wd_cnt_q, wd_cnt_d;
    logic             uart_tx_en_q, uart_tx_en_d;
    logic [7:0]       uart_tx_data_q, uart_tx_data_d;
    logic             timeout_err_q, timeout_err_d;

    logic [N_REQ-1:0] eligible;
    logic [1:0]       pick;
    logic             owner_en;
    logic             owner_req;
    logic             wd_kick;
    logic [2:0]       owner_inc;
    logic [4:0]       data_base;

    // First eligible index at or after ptr, wrapping modulo N_REQ.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] elig, input logic [1:0] ptr);
        logic [1:0] sel;
        logic       found;
        logic [2:0] idx;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= NReq) begin
                idx = idx - NReq;
            end
            if (!found && elig[idx[1:0]]) begin
                sel   = idx[1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign eligible  = req & ~lockout_q;
    assign pick      = rr_pick(eligible, rr_ptr_q);
    assign owner_en  = cli_tx_en[owner_q];
    assign owner_req = req[owner_q];
    assign wd_kick   = owner_en | uart_tx_busy | uart_tx_en_q;
    assign owner_inc = {1'b0, owner_q} + 3'd1;
    assign data_base = {owner_q, 3'b000};

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        lockout_d      = lockout_q & req;
        wd_cnt_d       = wd_cnt_q;
        uart_tx_en_d   = 1'b0;
        uart_tx_data_d = uart_tx_data_q;
        timeout_err_d  = 1'b0;
        timeout_id_d   = timeout_id_q;

        case (state_q)
            StIdle: begin
                if (|eligible) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    wd_cnt_d      = '0;
                    state_d       = StGrant;
                end
            end
            StGrant: begin
                uart_tx_en_d   = owner_en;
                uart_tx_data_d = cli_tx_data[data_base +: 8];
                // Release beats a watchdog expiry in the same cycle.
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = StDrain;
                end else if (TIMEOUT_CYC != 20'd0) begin
                    if (wd_kick) begin
                        wd_cnt_d = '0;
                    end else if (wd_cnt_q == TIMEOUT_CYC - 20'd1) begin
                        timeout_err_d      = 1'b1;
                        timeout_id_d       = owner_q;
                        lockout_d[owner_q] = 1'b1;
                        grant_d            = '0;
                        state_d            = StDrain;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 20'd1;
                    end
                end
            end
            StDrain: begin
                if (!uart_tx_busy && !uart_tx_en_q) begin
                    rr_ptr_d = (owner_inc >= NReq) ? 2'd0 : owner_inc[1:0];
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The uart_tx_en term covers the cycle between forwarding and the core raising busy.
    always_comb begin
        cli_tx_busy = '1;
        if (state_q == StGrant) begin
            cli_tx_busy[owner_q] = uart_tx_busy | uart_tx_en_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            lockout_q      <= '0;
            wd_cnt_q       <= '0;
            uart_tx_en_q   <= 1'b0;
            uart_tx_data_q <= '0;
            timeout_err_q  <= 1'b0;
            timeout_id_q   <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            lockout_q      <= lockout_d;
            wd_cnt_q       <= wd_cnt_d;
            uart_tx_en_q   <= uart_tx_en_d;
            uart_tx_data_q <= uart_tx_data_d;
            timeout_err_q  <= timeout_err_d;
            timeout_id_q   <= timeout_id_d;
        end
    end

    assign grant        = grant_q;
    assign uart_tx_en   = uart_tx_en_q;
    assign uart_tx_data = uart_tx_data_q;
    assign timeout_err  = timeout_err_q;
    assign timeout_id   = timeout_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of bytes expected at the UART plus per-scenario tasks.
module tb_uart_tx_arbiter;
    localparam int unsigned N = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   cli_tx_en = '0;
    logic [8*N-1:0] cli_tx_data = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   cli_tx_busy;
    logic           uart_tx_busy;
    logic           uart_tx_en;
    logic [7:0]     uart_tx_data;
    logic           timeout_err;
    logic [1:0]     timeout_id;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         busy_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ      (N),
        .TIMEOUT_CYC(20'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .cli_tx_en   (cli_tx_en),
        .cli_tx_data (cli_tx_data),
        .cli_tx_busy (cli_tx_busy),
        .uart_tx_busy(uart_tx_busy),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    // UART core model: busy for 4 cycles after each accepted byte.
    always @(posedge clk) begin
        if (!rst_n) busy_cnt <= 0;
        else if (uart_tx_en) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        #1;
        if (uart_tx_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected: got %02h, expected no byte", uart_tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (uart_tx_data !== mon_exp) begin
                    errors++;
                    $display("FAIL byte_data: got %02h, expected %02h", uart_tx_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        cli_tx_en = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input int idx, input logic [7:0] b, input bit drop);
        int n = 0;
        while (cli_tx_busy[idx] && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (cli_tx_busy[idx] !== 1'b0) begin
            errors++;
            $display("FAIL send_wait client %0d: busy=%b after %0d cycles, required 0",
                     idx, cli_tx_busy[idx], n);
        end
        cli_tx_en[idx]           = 1'b1;
        cli_tx_data[8*idx +: 8]  = b;
        if (drop) req[idx] = 1'b0;
        exp_q.push_back(b);
        tick();
        cli_tx_en[idx] = 1'b0;
        if (!drop) begin
            checks++;
            if (cli_tx_busy[idx] !== 1'b1) begin
                errors++;
                $display("FAIL busy_gap client %0d: busy=%b, required 1", idx, cli_tx_busy[idx]);
            end
        end
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        int n = 0;
        while (grant == '0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (grant !== exp) begin
            errors++;
            $display("FAIL %s: grant=%b after %0d cycles, required %b", name, grant, n, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== '0 || uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00 ||
            timeout_err !== 1'b0 || timeout_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b en=%b data=%02h err=%b id=%0d, required all 0",
                     grant, uart_tx_en, uart_tx_data, timeout_err, timeout_id);
        end
        checks++;
        if (cli_tx_busy !== 3'b111) begin
            errors++;
            $display("FAIL reset_busy: cli_tx_busy=%b, required 111", cli_tx_busy);
        end
    endtask

    task automatic test_single_client();
        req = 3'b001;
        tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL grant_latency: grant=%b, required 001", grant);
        end
        checks++;
        if (cli_tx_busy[2:1] !== 2'b11) begin
            errors++;
            $display("FAIL nonowner_busy: cli_tx_busy=%b, required 11x", cli_tx_busy);
        end
        send(0, 8'h32, 1'b0);
        send(0, 8'h0D, 1'b0);
        send(0, 8'h0A, 1'b1);
        checks++;
        if (grant !== 3'b000 || uart_tx_en !== 1'b1) begin
            errors++;
            $display("FAIL release_byte: grant=%b en=%b, required grant 000 en 1",
                     grant, uart_tx_en);
        end
        repeat (8) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_grant(3'(1 << i), "rr_order");
            send(i, 8'(16 + i), 1'b1);
        end
        req = 3'b011;
        wait_grant(3'b001, "rr_wrap");
        req = 3'b000;
        repeat (8) tick();
    endtask

    task automatic test_nonowner_ignored();
        int zeros = 0;
        bit bad = 1'b0;
        do_reset();
        req = 3'b110;
        wait_grant(3'b010, "owner_client1");
        cli_tx_en[2]      = 1'b1;
        cli_tx_data[23:16] = 8'h41;
        for (int k = 0; k < 4; k++) begin
            tick();
            cli_tx_en[2] = 1'b0;
            if (uart_tx_en !== 1'b0 || cli_tx_busy[2] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL nonowner_strobe: en=%b busy2=%b, required en 0 busy2 1",
                     uart_tx_en, cli_tx_busy[2]);
        end
        send(1, 8'h55, 1'b0);
        while (cli_tx_busy[1] && zeros < 40) begin
            tick();
            zeros++;
        end
        zeros = 0;
        req = 3'b100;
        tick();
        while (grant == '0 && zeros < 40) begin
            zeros++;
            tick();
        end
        checks++;
        if (grant !== 3'b100 || zeros != 2) begin
            errors++;
            $display("FAIL handover_gap: grant=%b after %0d idle cycles, required 100 after 2",
                     grant, zeros);
        end
        req = 3'b000;
        repeat (8) tick();
    endtask

    task automatic test_release_vs_timeout();
        bit seen = 1'b0;
        do_reset();
        req = 3'b001;
        wait_grant(3'b001, "rvt_grant");
        repeat (15) tick();
        req = 3'b000;
        tick();
        checks++;
        if (timeout_err !== 1'b0 || grant !== 3'b000) begin
            errors++;
            $display("FAIL release_wins: err=%b grant=%b, required err 0 grant 000",
                     timeout_err, grant);
        end
        repeat (6) begin
            tick();
            if (timeout_err !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL release_no_err: timeout_err=1 seen, required 0");
        end
        req = 3'b001;
        wait_grant(3'b001, "release_no_lockout");
        req = 3'b000;
        repeat (8) tick();
    endtask

    task automatic test_watchdog();
        bit early = 1'b0;
        int n = 0;
        do_reset();
        req = 3'b001;
        wait_grant(3'b001, "wd_grant");
        for (int k = 1; k < 16; k++) begin
            tick();
            if (timeout_err !== 1'b0 || grant !== 3'b001) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL wd_early: grant revoked or error before cycle 16, required held");
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || grant !== 3'b000 || timeout_id !== 2'd0) begin
            errors++;
            $display("FAIL wd_expire: err=%b grant=%b id=%0d, required err 1 grant 000 id 0",
                     timeout_err, grant, timeout_id);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_pulse: err=%b one cycle later, required 0", timeout_err);
        end
        repeat (10) tick();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL wd_lockout: grant=%b with req held, required 000", grant);
        end
        req = 3'b000;
        tick();
        req = 3'b001;
        wait_grant(3'b001, "wd_regrant");
        req = 3'b000;
        repeat (6) tick();
        req = 3'b010;
        wait_grant(3'b010, "wd_client1");
        while (timeout_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (timeout_err !== 1'b1 || timeout_id !== 2'd1) begin
            errors++;
            $display("FAIL wd_id: err=%b id=%0d, required err 1 id 1", timeout_err, timeout_id);
        end
        req = 3'b000;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid_forward();
        req = 3'b001;
        wait_grant(3'b001, "rst_grant");
        cli_tx_en[0]     = 1'b1;
        cli_tx_data[7:0] = 8'h77;
        exp_q.push_back(8'h77);
        tick();
        cli_tx_data[7:0] = 8'h78;
        rst_n = 1'b0;
        tick();
        checks++;
        if (uart_tx_en !== 1'b0 || grant !== 3'b000 || uart_tx_data !== 8'h00 ||
            timeout_err !== 1'b0 || timeout_id !== 2'd0 || cli_tx_busy !== 3'b111) begin
            errors++;
            $display("FAIL rst_mid: en=%b grant=%b data=%02h err=%b id=%0d busy=%b, required reset",
                     uart_tx_en, grant, uart_tx_data, timeout_err, timeout_id, cli_tx_busy);
        end
        cli_tx_en = '0;
        req       = '0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_client();
        test_back_to_back();
        test_nonowner_ignored();
        test_release_vs_timeout();
        test_watchdog();
        test_reset_mid_forward();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes never reached the UART, required 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
